// File: rtl/grid_game_engine.sv
// Two-player N x N, K-in-a-row game engine.
// Holds the board, arbitrates turns, and scans one direction per cycle for a win or draw.
module grid_game_engine #(
    parameter int N            = 3,
    parameter int K            = 3,
    parameter int FIRST_PLAYER = 1,
    localparam int IDX_W       = (N < 2) ? 1 : $clog2(N)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 move_valid,
    output logic                 move_ready,
    input  logic [IDX_W-1:0]     move_row,
    input  logic [IDX_W-1:0]     move_col,
    output logic                 move_ok,
    output logic                 move_err,
    output logic [1:0]           err_code,
    output logic [1:0]           turn,
    output logic [2*N*N-1:0]     board,
    output logic [6:0]           move_count,
    output logic                 game_over,
    output logic [1:0]           winner
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    localparam int CELLS = N * N;
    localparam logic [1:0] P_FIRST = (FIRST_PLAYER == 2) ? 2'b10 : 2'b01;

    state_t             state_q, state_d;
    logic [2*N*N-1:0]   board_q, board_d;
    logic [6:0]         move_count_q, move_count_d;
    logic [1:0]         turn_q, turn_d;
    logic [1:0]         winner_q, winner_d;
    logic [1:0]         err_code_q, err_code_d;
    logic [1:0]         dir_q, dir_d;
    logic               move_ok_q, move_ok_d;
    logic               move_err_q, move_err_d;
    logic               game_over_q, game_over_d;
    logic [IDX_W-1:0]   row_q, row_d;
    logic [IDX_W-1:0]   col_q, col_d;

    int                 step_r;
    int                 step_c;
    int                 run_len;
    int                 tgt;
    logic               live_p;
    logic               live_n;
    logic               out_of_range;

    // Off-board coordinates read as empty so they never extend a run.
    function automatic logic [1:0] cell_at(input logic [2*N*N-1:0] b,
                                           input int r,
                                           input int c);
        logic [1:0] v;
        v = 2'b00;
        if (r >= 0 && r < N && c >= 0 && c < N) begin
            for (int i = 0; i < CELLS; i++) begin
                if (i == r * N + c) begin
                    v = b[2*i +: 2];
                end
            end
        end
        return v;
    endfunction

    // Run length through the latched cell along the direction under test.
    always_comb begin
        step_r = 1;
        step_c = 0;
        unique case (dir_q)
            2'd0:    begin step_r = 0; step_c = 1;  end
            2'd1:    begin step_r = 1; step_c = 0;  end
            2'd2:    begin step_r = 1; step_c = 1;  end
            default: begin step_r = 1; step_c = -1; end
        endcase
        run_len = 1;
        live_p  = 1'b1;
        live_n  = 1'b1;
        for (int s = 1; s < K; s++) begin
            live_p = live_p && (cell_at(board_q,
                                        int'(row_q) + s * step_r,
                                        int'(col_q) + s * step_c) == turn_q);
            live_n = live_n && (cell_at(board_q,
                                        int'(row_q) - s * step_r,
                                        int'(col_q) - s * step_c) == turn_q);
            if (live_p) run_len = run_len + 1;
            if (live_n) run_len = run_len + 1;
        end
    end

    // Next state, board update and registered output values.
    always_comb begin
        state_d      = state_q;
        board_d      = board_q;
        move_count_d = move_count_q;
        turn_d       = turn_q;
        winner_d     = winner_q;
        err_code_d   = err_code_q;
        dir_d        = dir_q;
        row_d        = row_q;
        col_d        = col_q;
        move_ok_d    = 1'b0;
        move_err_d   = 1'b0;
        tgt          = int'(move_row) * N + int'(move_col);
        out_of_range = (int'(move_row) >= N) || (int'(move_col) >= N);

        if (start) begin
            board_d      = '0;
            move_count_d = '0;
            winner_d     = 2'b00;
            err_code_d   = 2'b00;
            turn_d       = P_FIRST;
            dir_d        = 2'd0;
            state_d      = S_WAIT;
        end else begin
            unique case (state_q)
                S_WAIT: begin
                    if (move_valid) begin
                        if (out_of_range) begin
                            move_err_d = 1'b1;
                            err_code_d = 2'b10;
                        end else if (cell_at(board_q, int'(move_row),
                                             int'(move_col)) != 2'b00) begin
                            move_err_d = 1'b1;
                            err_code_d = 2'b01;
                        end else begin
                            for (int i = 0; i < CELLS; i++) begin
                                if (i == tgt) board_d[2*i +: 2] = turn_q;
                            end
                            move_count_d = move_count_q + 7'd1;
                            move_ok_d    = 1'b1;
                            err_code_d   = 2'b00;
                            row_d        = move_row;
                            col_d        = move_col;
                            dir_d        = 2'd0;
                            state_d      = S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if (run_len >= K) begin
                        winner_d = turn_q;
                        turn_d   = 2'b00;
                        state_d  = S_DONE;
                    end else if (dir_q != 2'd3) begin
                        dir_d = dir_q + 2'd1;
                    end else if (move_count_q == 7'(CELLS)) begin
                        winner_d = 2'b00;
                        turn_d   = 2'b00;
                        state_d  = S_DONE;
                    end else begin
                        turn_d  = (turn_q == 2'b01) ? 2'b10 : 2'b01;
                        state_d = S_WAIT;
                    end
                end
                default: begin
                end
            endcase
        end

        game_over_d = (state_d == S_DONE);
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            board_q      <= '0;
            move_count_q <= '0;
            turn_q       <= 2'b00;
            winner_q     <= 2'b00;
            err_code_q   <= 2'b00;
            dir_q        <= 2'd0;
            row_q        <= '0;
            col_q        <= '0;
            move_ok_q    <= 1'b0;
            move_err_q   <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            board_q      <= board_d;
            move_count_q <= move_count_d;
            turn_q       <= turn_d;
            winner_q     <= winner_d;
            err_code_q   <= err_code_d;
            dir_q        <= dir_d;
            row_q        <= row_d;
            col_q        <= col_d;
            move_ok_q    <= move_ok_d;
            move_err_q   <= move_err_d;
            game_over_q  <= game_over_d;
        end
    end

    assign move_ready = (state_q == S_WAIT);
    assign move_ok    = move_ok_q;
    assign move_err   = move_err_q;
    assign err_code   = err_code_q;
    assign turn       = turn_q;
    assign board      = board_q;
    assign move_count = move_count_q;
    assign game_over  = game_over_q;
    assign winner     = winner_q;

endmodule
